// File: rtl/alu_exec_stage.sv
// alu_exec_stage: EX stage of a simple pipeline.
// A combinational ALU feeds a 2-entry skid buffer. The main entry drives the
// outputs and the skid entry catches one extra operation while downstream stalls.
//
// Handshake: an operation moves in when in_valid && in_ready. It moves out when
// out_valid && out_ready. in_ready is registered, so nothing combinational runs
// from out_ready to in_ready. Data outputs hold their last value while
// out_valid=0, and consumers must qualify them with out_valid. flush empties
// both entries at the next edge and overrides every transfer in that cycle.
module alu_exec_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ALUControl,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic [REG_W-1:0]  WriteRegIn,
    input  logic              RegWriteIn,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic              Overflow,
    output logic              IllegalOp,
    output logic [REG_W-1:0]  WriteRegOut,
    output logic              RegWriteOut
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              ovf;
        logic              illegal;
        logic [REG_W-1:0]  wreg;
        logic              regwrite;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    entry_t new_c;

    logic [DATA_W-1:0] sum_c;
    logic [DATA_W-1:0] diff_c;
    logic              in_fire;
    logic              out_fire;

    assign sum_c  = SrcA + SrcB;
    assign diff_c = SrcA - SrcB;

    // ALU: build the operation's result record from the current inputs
    always_comb begin
        new_c          = '0;
        new_c.wreg     = WriteRegIn;
        case (ALUControl)
            4'b0010: begin
                new_c.result = sum_c;
                new_c.ovf    = (SrcA[DATA_W-1] == SrcB[DATA_W-1]) &&
                               (sum_c[DATA_W-1] != SrcA[DATA_W-1]);
            end
            4'b0110: begin
                new_c.result = diff_c;
                new_c.ovf    = (SrcA[DATA_W-1] != SrcB[DATA_W-1]) &&
                               (diff_c[DATA_W-1] != SrcA[DATA_W-1]);
            end
            4'b0000: new_c.result = SrcA & SrcB;
            4'b0001: new_c.result = SrcA | SrcB;
            // True signed compare; the wrapped difference sign would be wrong on overflow
            4'b0111: new_c.result = {{(DATA_W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: new_c.illegal = 1'b1;
        endcase
        new_c.zero     = (new_c.result == '0);
        new_c.regwrite = RegWriteIn && !new_c.illegal;
    end

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = (state_q != S_EMPTY) && out_ready;

    // Next state and entry updates of the skid buffer; flush wins over any transfer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_d  = new_c;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = new_c;
                    end else if (in_fire) begin
                        skid_d  = new_c;
                        state_d = S_TWO;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        in_ready_d = (state_d != S_TWO);
    end

    // State, entries and the registered ready; reset returns everything to EMPTY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_EMPTY;
            in_ready_q       <= 1'b1;
            main_q.result    <= '0;
            main_q.zero      <= 1'b1;
            main_q.ovf       <= 1'b0;
            main_q.illegal   <= 1'b0;
            main_q.wreg      <= '0;
            main_q.regwrite  <= 1'b0;
            skid_q           <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != S_EMPTY);
    assign ALUResult   = main_q.result;
    assign Zero        = main_q.zero;
    assign Overflow    = main_q.ovf;
    assign IllegalOp   = main_q.illegal;
    assign WriteRegOut = main_q.wreg;
    assign RegWriteOut = main_q.regwrite;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: vector table, directed handshake sequences and a random
// run checked against a queue-based reference model.
module tb_alu_exec_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ALUControl;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic [RW-1:0] WriteRegIn;
    logic          RegWriteIn;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ALUResult;
    logic          Zero;
    logic          Overflow;
    logic          IllegalOp;
    logic [RW-1:0] WriteRegOut;
    logic          RegWriteOut;

    int n_checks;
    int n_errors;

    alu_exec_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
        .WriteRegIn(WriteRegIn), .RegWriteIn(RegWriteIn),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow),
        .IllegalOp(IllegalOp), .WriteRegOut(WriteRegOut), .RegWriteOut(RegWriteOut)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected output record: {result, zero, ovf, illegal, wreg, regwrite}
    typedef struct packed {
        logic [DW-1:0] result;
        logic          zero;
        logic          ovf;
        logic          illegal;
        logic [RW-1:0] wreg;
        logic          regwrite;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [3:0]    ctrl;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] wreg;
        logic          rw;
        exp_t          exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_outputs(input string name, input exp_t e);
        check({name, ".result"}, 64'(ALUResult), 64'(e.result));
        check({name, ".zero"}, 64'(Zero), 64'(e.zero));
        check({name, ".ovf"}, 64'(Overflow), 64'(e.ovf));
        check({name, ".illegal"}, 64'(IllegalOp), 64'(e.illegal));
        check({name, ".wreg"}, 64'(WriteRegOut), 64'(e.wreg));
        check({name, ".regwrite"}, 64'(RegWriteOut), 64'(e.regwrite));
    endtask

    // Reference model: plain signed integer arithmetic, overflow by range test
    function automatic exp_t model(input logic [3:0] ctrl, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [RW-1:0] wreg,
                                   input logic rw);
        exp_t   e;
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '0;
        e.wreg = wreg;
        r = 0;
        case (ctrl)
            4'd2: begin r = sa + sb; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd6: begin r = sa - sb; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd0: r = longint'(a & b);
            4'd1: r = longint'(a | b);
            4'd7: r = (sa < sb) ? 1 : 0;
            default: e.illegal = 1'b1;
        endcase
        e.result   = r[DW-1:0];
        e.zero     = (e.result == 0);
        e.regwrite = rw && !e.illegal;
        return e;
    endfunction

    // driver tasks
    task automatic drive_op(input logic [3:0] ctrl, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [RW-1:0] wreg, input logic rw);
        in_valid   = 1'b1;
        ALUControl = ctrl;
        SrcA       = a;
        SrcB       = b;
        WriteRegIn = wreg;
        RegWriteIn = rw;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        ALUControl = 4'd0;
        SrcA       = '0;
        SrcB       = '0;
        WriteRegIn = '0;
        RegWriteIn = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        exp_t r;
        r = '0;
        r.zero = 1'b1;
        check({name, ".out_valid"}, 64'(out_valid), 64'd0);
        check({name, ".in_ready"}, 64'(in_ready), 64'd1);
        check_outputs(name, r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    // Fill both entries while downstream stalls, leaving the stage in TWO
    task automatic fill_two();
        out_ready = 1'b0;
        drive_op(4'd2, 32'd100, 32'd1, 5'd1, 1'b1);
        @(negedge clk);
        drive_op(4'd2, 32'd200, 32'd2, 5'd2, 1'b1);
        @(negedge clk);
        idle_inputs();
        check("fill_two.in_ready", 64'(in_ready), 64'd0);
    endtask

    initial begin
        exp_t       e;
        exp_t       ea, eb, ec;
        logic [3:0] ctrl;
        logic [DW-1:0] a, b;
        logic [RW-1:0] wr;
        logic       rw, iv, orr, fl;
        logic [DW-1:0] corner[6];

        n_checks = 0;
        n_errors = 0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        do_reset();

        // vector table
        vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd8, 1'b1, exp_t'{32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1}};
        vecs[1]  = '{4'b0110, 32'd5, 32'd5, 5'd3, 1'b1, exp_t'{32'h0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1}};
        vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b1, exp_t'{32'h1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1}};
        vecs[3]  = '{4'b1111, 32'h1234, 32'h5678, 5'd9, 1'b1, exp_t'{32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0}};
        vecs[4]  = '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd10, 1'b0, exp_t'{32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0}};
        vecs[5]  = '{4'b0001, 32'h1234_0000, 32'h0000_5678, 5'd11, 1'b1, exp_t'{32'h1234_5678, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1}};
        vecs[6]  = '{4'b0110, 32'h8000_0000, 32'h1, 5'd12, 1'b1, exp_t'{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd12, 1'b1}};
        vecs[7]  = '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd13, 1'b1, exp_t'{32'h1, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1}};
        vecs[8]  = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd14, 1'b1, exp_t'{32'h0, 1'b1, 1'b0, 1'b0, 5'd14, 1'b1}};
        vecs[9]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd15, 1'b1, exp_t'{32'h0, 1'b1, 1'b0, 1'b0, 5'd15, 1'b1}};
        vecs[10] = '{4'b0011, 32'h1, 32'h1, 5'd31, 1'b1, exp_t'{32'h0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0}};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].wreg, vecs[i].rw);
            @(negedge clk);
            idle_inputs();
            check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp);
        end
        @(negedge clk);
        check("drain.out_valid", 64'(out_valid), 64'd0);

        // back-to-back sub then slt, results on consecutive cycles
        drive_op(4'b0110, 32'd5, 32'd5, 5'd1, 1'b1);
        @(negedge clk);
        drive_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
        check("b2b.first.valid", 64'(out_valid), 64'd1);
        check("b2b.first.result", 64'(ALUResult), 64'd0);
        check("b2b.first.zero", 64'(Zero), 64'd1);
        @(negedge clk);
        idle_inputs();
        check("b2b.second.valid", 64'(out_valid), 64'd1);
        check("b2b.second.result", 64'(ALUResult), 64'd1);
        check("b2b.second.zero", 64'(Zero), 64'd0);
        @(negedge clk);

        // stall: A, B accepted, C waits; release emits A, B, C in order
        ea = model(4'd2, 32'd1, 32'd2, 5'd5, 1'b1);
        eb = model(4'd1, 32'h10, 32'h01, 5'd6, 1'b1);
        ec = model(4'd6, 32'd10, 32'd3, 5'd7, 1'b1);
        out_ready = 1'b0;
        drive_op(4'd2, 32'd1, 32'd2, 5'd5, 1'b1);
        @(negedge clk);
        check("stall.n1.in_ready", 64'(in_ready), 64'd1);
        check_outputs("stall.n1", ea);
        drive_op(4'd1, 32'h10, 32'h01, 5'd6, 1'b1);
        @(negedge clk);
        check("stall.n2.in_ready", 64'(in_ready), 64'd0);
        check_outputs("stall.n2", ea);
        drive_op(4'd6, 32'd10, 32'd3, 5'd7, 1'b1);
        @(negedge clk);
        check("stall.n3.in_ready", 64'(in_ready), 64'd0);
        check_outputs("stall.n3", ea);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall.n4.valid", 64'(out_valid), 64'd1);
        check_outputs("stall.n4", eb);
        @(negedge clk);
        idle_inputs();
        check("stall.n5.valid", 64'(out_valid), 64'd1);
        check_outputs("stall.n5", ec);
        @(negedge clk);
        check("stall.n6.valid", 64'(out_valid), 64'd0);

        // flush from TWO with a same-cycle input
        fill_two();
        flush = 1'b1;
        drive_op(4'd2, 32'd7, 32'd7, 5'd3, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("flush.after.out_valid", 64'(out_valid), 64'd0);
        end

        // asynchronous reset while in TWO
        fill_two();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive_op(4'd6, 32'd9, 32'd4, 5'd20, 1'b1);
        @(negedge clk);
        idle_inputs();
        check("post_reset.valid", 64'(out_valid), 64'd1);
        check_outputs("post_reset", model(4'd6, 32'd9, 32'd4, 5'd20, 1'b1));
        @(negedge clk);

        // randomized run against the queue model
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        corner[5] = 32'h5555_5555;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rnd.out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("rnd.in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (exp_q.size() > 0 && out_valid) check_outputs("rnd", exp_q[0]);
            ctrl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                 : ($urandom_range(0, 4) == 0 ? 4'd0 : ($urandom_range(0, 1) ? 4'd2 : ($urandom_range(0, 1) ? 4'd6 : ($urandom_range(0, 1) ? 4'd7 : 4'd1))));
            a   = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : DW'($urandom);
            b   = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : DW'($urandom);
            wr  = RW'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            drive_op(ctrl, a, b, wr, rw);
            in_valid  = iv;
            out_ready = orr;
            flush     = fl;
            if (fl) begin
                exp_q.delete();
            end else begin
                if (orr && exp_q.size() > 0) void'(exp_q.pop_front());
                if (iv && in_ready) begin
                    e = model(ctrl, a, b, wr, rw);
                    exp_q.push_back(e);
                end
            end
            @(negedge clk);
        end

        flush = 1'b0;
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have exactly these parameters (name, default, meaning):
- DATA_W, 32, operand/result width
- REG_W, 5, destination register index width
REQ-002 The block SHALL have exactly these ports (name direction width meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream (ID/EX) presents an operation
- in_ready  out  1  stage can accept an operation this cycle
- ALUControl  in  4  operation code from the ALU decoder
- SrcA  in  DATA_W  operand A
- SrcB  in  DATA_W  operand B
- WriteRegIn  in  REG_W  destination register, passed through
- RegWriteIn  in  1  register-write enable, passed through
- flush  in  1  discard all held and incoming operations
- out_valid  out  1  EX/MEM result held
- out_ready  in  1  downstream (EX/MEM consumer) accepts the result
- ALUResult  out  DATA_W  registered result
- Zero  out  1  registered (ALUResult == 0)
- Overflow  out  1  registered signed overflow, add/sub only
- IllegalOp  out  1  registered: ALUControl code unsupported
- WriteRegOut  out  REG_W  registered destination register
- RegWriteOut  out  1  registered write enable; forced 0 when IllegalOp

Function
REQ-003 Supported codes SHALL be: 0010 add, 0110 sub (A-B), 0000 AND, 0001 OR, 0111 slt (signed A<B gives 1, else 0, zero-extended).
REQ-004 Any other code SHALL produce ALUResult=0, Zero=1, Overflow=0, IllegalOp=1, RegWriteOut=0.
REQ-005 Arithmetic SHALL be modulo 2^DATA_W; Overflow=1 only when add/sub operands' signs produce a result whose sign is inconsistent (two's-complement rule); slt SHALL use the true signed comparison, not the wrapped subtraction sign.
REQ-006 Computation SHALL be combinational from inputs; results SHALL be registered; latency from accepted input to out_valid = 1 cycle.
REQ-007 Storage SHALL be a 2-entry skid buffer: main register (drives outputs) and skid register.
REQ-008 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-009 in_ready SHALL be a registered signal equal to NOT skid_valid (no combinational path from out_ready).
REQ-010 States: EMPTY (main and skid empty), ONE (main full), TWO (main and skid full).
REQ-011 EMPTY: transfer in -> ONE.
REQ-012 ONE: in and out together -> ONE with new data in main; in only -> TWO, new data in skid; out only -> EMPTY; neither -> ONE, hold.
REQ-013 TWO: in_ready=0; out -> ONE, skid contents move to main; no out -> TWO, hold.
REQ-014 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 Operations SHALL leave in acceptance order; none dropped or duplicated absent flush.
REQ-016 flush=1 SHALL, at the next edge, empty both entries (EMPTY, in_ready=1), discarding any same-cycle input; flush overrides all other transfers.
REQ-017 out_valid=0 SHALL not by itself clear data outputs; consumers qualify with out_valid.

Reset
REQ-018 rst_n=0 SHALL immediately, without a clock, force EMPTY, in_ready=1, out_valid=0, ALUResult=0, Zero=1, Overflow=0, IllegalOp=0, WriteRegOut=0, RegWriteOut=0, skid contents=0.
REQ-019 Reset asserted mid-operation SHALL discard held operations; first edge after release behaves as EMPTY.

Verification
REQ-020 add 0x7FFFFFFF+1, WriteRegIn=8, RegWriteIn=1, out_ready=1 -> next cycle out_valid=1, ALUResult=0x80000000, Overflow=1, Zero=0, WriteRegOut=8.
REQ-021 sub 5-5 then slt 0xFFFFFFFF,1 back-to-back -> results 0 (Zero=1), then 1 (Zero=0), consecutive cycles.
REQ-022 out_ready=0, issue ops A,B,C -> A,B accepted, in_ready=0 after B; raise out_ready -> A, B, C emerge in order, outputs stable while stalled.
REQ-023 ALUControl=1111, RegWriteIn=1 -> ALUResult=0, IllegalOp=1, RegWriteOut=0.
REQ-024 TWO state with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing later emerges.
REQ-025 rst_n low between edges while in TWO -> outputs reach reset values before next edge; post-release op completes with 1-cycle latency.
